// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
// Watches the 2-bit light code driven by a traffic controller, drives
// registered one-hot lamps, and flags illegal codes, illegal transitions
// and (optionally) codes that dwell too long. Counts completed
// RED-GREEN-YELLOW cycles while the monitor is tracking.
//
// Optional feature: define TL_MON_DWELL_CHECK_EN to compile in the dwell
// counter and err_stall detection. Without it err_stall is tied low.
//
// Monitor states: SYNC (waiting for RED), TRACK (checking), FAULT (latched
// until clr). The current state is held in the 'state' signal.
module traffic_light_monitor #(
   parameter int CNT_W     = 8,
   parameter int MAX_DWELL = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       state_in,
   input  logic             clr,
   output logic             lamp_red,
   output logic             lamp_green,
   output logic             lamp_yellow,
   output logic             err_code,
   output logic             err_seq,
   output logic             err_stall,
   output logic             fault,
   output logic [CNT_W-1:0] cycle_count
);

   localparam logic [1:0] C_RED    = 2'b00;
   localparam logic [1:0] C_GREEN  = 2'b01;
   localparam logic [1:0] C_YELLOW = 2'b10;
   localparam logic [1:0] C_BAD    = 2'b11;

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } mon_state_t;

   mon_state_t state;
   mon_state_t state_nxt;
   logic [1:0] s_cur;

   logic code_bad;
   logic legal_tr;
   logic seq_bad;
   logic stall_hit;
   logic cyc_evt;

   // Transition classification between the previous sample and the new one.
   always_comb begin
      code_bad = (state_in == C_BAD);
      legal_tr = (state_in == s_cur) ||
                 ((s_cur == C_RED)    && (state_in == C_GREEN))  ||
                 ((s_cur == C_GREEN)  && (state_in == C_YELLOW)) ||
                 ((s_cur == C_YELLOW) && (state_in == C_RED));
      // Transitions out of the illegal code are not sequence-checked, and
      // transitions into it are reported as err_code only.
      seq_bad  = (state == TRACK) && (s_cur != C_BAD) && !code_bad && !legal_tr;
      cyc_evt  = (state == TRACK) && (s_cur == C_YELLOW) && (state_in == C_RED);
   end

`ifdef TL_MON_DWELL_CHECK_EN
   localparam int DW_W = $clog2(MAX_DWELL + 2);
   localparam logic [DW_W-1:0] DW_LIM = DW_W'(MAX_DWELL + 1);

   logic [DW_W-1:0] dwell;
   logic [DW_W-1:0] dwell_nxt;

   // Dwell restarts at 1 on every code change and saturates at the limit so
   // the stall pulse fires once per excessive hold.
   always_comb begin
      if (state_in != s_cur) begin
         dwell_nxt = DW_W'(1);
      end else if (dwell == DW_LIM) begin
         dwell_nxt = DW_LIM;
      end else begin
         dwell_nxt = dwell + DW_W'(1);
      end
      stall_hit = (state == TRACK) && (state_in == s_cur) &&
                  (dwell != DW_LIM) && (dwell_nxt == DW_LIM);
   end

   // Dwell counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dwell <= DW_W'(1);
      end else begin
         dwell <= dwell_nxt;
      end
   end
`else
   // Dwell checking compiled out: a long hold is never a fault.
   always_comb begin
      stall_hit = 1'b0;
   end
`endif

   // Monitor next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         SYNC: begin
            if (state_in == C_RED) begin
               state_nxt = TRACK;
            end
         end
         TRACK: begin
            if (code_bad || seq_bad || stall_hit) begin
               state_nxt = FAULT;
            end
         end
         FAULT: begin
            // clr wins over any simultaneous error.
            if (clr) begin
               state_nxt = SYNC;
            end
         end
         default: begin
            state_nxt = SYNC;
         end
      endcase
   end

   // State, sample register and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= SYNC;
         s_cur       <= C_RED;
         lamp_red    <= 1'b1;
         lamp_green  <= 1'b0;
         lamp_yellow <= 1'b0;
         err_code    <= 1'b0;
         err_seq     <= 1'b0;
         err_stall   <= 1'b0;
         fault       <= 1'b0;
         cycle_count <= '0;
      end else begin
         state       <= state_nxt;
         s_cur       <= state_in;
         // Illegal code falls back to red only.
         lamp_red    <= (state_in == C_RED) || (state_in == C_BAD);
         lamp_green  <= (state_in == C_GREEN);
         lamp_yellow <= (state_in == C_YELLOW);
         err_code    <= code_bad;
         err_seq     <= seq_bad;
         err_stall   <= stall_hit;
         fault       <= (state_nxt == FAULT);
         if (cyc_evt) begin
            cycle_count <= cycle_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor (CNT_W=2 to exercise wrap).
module tb_traffic_light_monitor;

   logic       clk;
   logic       rst;
   logic [1:0] state_in;
   logic       clr;
   logic       lamp_red;
   logic       lamp_green;
   logic       lamp_yellow;
   logic       err_code;
   logic       err_seq;
   logic       err_stall;
   logic       fault;
   logic [1:0] cycle_count;

   int n_checks;
   int n_fail;
   logic [1:0] exp_cnt;

`ifdef TL_MON_DWELL_CHECK_EN
   localparam bit DWELL_EN = 1'b1;
`else
   localparam bit DWELL_EN = 1'b0;
`endif

   traffic_light_monitor #(.CNT_W(2), .MAX_DWELL(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .state_in   (state_in),
      .clr        (clr),
      .lamp_red   (lamp_red),
      .lamp_green (lamp_green),
      .lamp_yellow(lamp_yellow),
      .err_code   (err_code),
      .err_seq    (err_seq),
      .err_stall  (err_stall),
      .fault      (fault),
      .cycle_count(cycle_count)
   );

   // Clock and reset generation.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed output bundle: {r,g,y,err_code,err_seq,err_stall,fault,count}.
   function automatic logic [8:0] obs();
      return {lamp_red, lamp_green, lamp_yellow, err_code, err_seq,
              err_stall, fault, cycle_count};
   endfunction

   // Expected output bundle built from the sampled code and expected flags.
   function automatic logic [8:0] expv(input logic [1:0] code, input logic ec,
                                       input logic es, input logic est,
                                       input logic f, input logic [1:0] cnt);
      logic r, g, y;
      r = (code == 2'b00) || (code == 2'b11);
      g = (code == 2'b01);
      y = (code == 2'b10);
      return {r, g, y, ec, es, est, f, cnt};
   endfunction

   // Driver: present one sample, then step just past the edge that takes it.
   task automatic apply(input logic [1:0] code, input logic c);
      state_in = code;
      clr      = c;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [8:0] e;
      rst = 1'b1; state_in = 2'b01; clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      e = 9'b100_000_0_00;
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL reset_state got=%b exp=%b", obs(), e); end
      rst = 1'b0;
      exp_cnt = 2'd0;
   endtask

   // Five full cycles as 00,01,10,00 groups; also covers the 2-bit wrap.
   task automatic test_cycles();
      logic [1:0] codes [4];
      logic [8:0] e;
      codes[0] = 2'b00; codes[1] = 2'b01; codes[2] = 2'b10; codes[3] = 2'b00;
      for (int g = 0; g < 5; g++) begin
         for (int j = 0; j < 4; j++) begin
            apply(codes[j], 1'b0);
            if (j == 3) exp_cnt = exp_cnt + 2'd1;
            e = expv(codes[j], 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt);
            n_checks++;
            if (obs() !== e) begin
               n_fail++; $display("FAIL cycles g=%0d j=%0d got=%b exp=%b", g, j, obs(), e);
            end
         end
      end
      n_checks++;
      if (cycle_count !== 2'd1) begin n_fail++; $display("FAIL cycle_wrap got=%0d exp=1", cycle_count); end
   endtask

   task automatic test_seq_error();
      logic [8:0] e;
      apply(2'b00, 1'b0);
      apply(2'b10, 1'b0);
      e = expv(2'b10, 1'b0, 1'b1, 1'b0, 1'b1, exp_cnt);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL seq_err got=%b exp=%b", obs(), e); end
      apply(2'b10, 1'b1);
      e = expv(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL seq_clr got=%b exp=%b", obs(), e); end
      // In SYNC an out-of-order step must not be flagged.
      apply(2'b01, 1'b0);
      e = expv(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL seq_sync_nocheck got=%b exp=%b", obs(), e); end
      apply(2'b00, 1'b0);
      e = expv(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL seq_resync got=%b exp=%b", obs(), e); end
   endtask

   task automatic test_code_error();
      logic [8:0] e;
      apply(2'b11, 1'b0);
      e = expv(2'b11, 1'b1, 1'b0, 1'b0, 1'b1, exp_cnt);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL code_track got=%b exp=%b", obs(), e); end
      // clr and error together: error still reported, clr wins.
      apply(2'b11, 1'b1);
      e = expv(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, exp_cnt);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL code_clr_wins got=%b exp=%b", obs(), e); end
      apply(2'b11, 1'b0);
      e = expv(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, exp_cnt);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL code_sync got=%b exp=%b", obs(), e); end
      apply(2'b01, 1'b0);
      e = expv(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL code_exit got=%b exp=%b", obs(), e); end
      apply(2'b00, 1'b0);
      e = expv(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL code_resync got=%b exp=%b", obs(), e); end
   endtask

   task automatic test_clr_ignored();
      logic [8:0] e;
      apply(2'b00, 1'b1);
      e = expv(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL clr_track got=%b exp=%b", obs(), e); end
      // Still tracking: RED->YELLOW must be caught.
      apply(2'b10, 1'b0);
      e = expv(2'b10, 1'b0, 1'b1, 1'b0, 1'b1, exp_cnt);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL clr_ignored got=%b exp=%b", obs(), e); end
      apply(2'b10, 1'b1);
      // YELLOW->RED seen in SYNC must not count.
      apply(2'b00, 1'b0);
      e = expv(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL count_hold_sync got=%b exp=%b", obs(), e); end
   endtask

   task automatic test_stall();
      logic [8:0] e;
      logic st, f;
      int pulses;
      pulses = 0;
      for (int i = 1; i <= 19; i++) begin
         apply(2'b01, 1'b0);
         st = DWELL_EN && (i == 17);
         f  = DWELL_EN && (i >= 17);
         if (err_stall === 1'b1) pulses++;
         e = expv(2'b01, 1'b0, 1'b0, st, f, exp_cnt);
         n_checks++;
         if (obs() !== e) begin n_fail++; $display("FAIL stall i=%0d got=%b exp=%b", i, obs(), e); end
      end
      n_checks++;
      if (pulses !== (DWELL_EN ? 1 : 0)) begin
         n_fail++; $display("FAIL stall_pulses got=%0d exp=%0d", pulses, DWELL_EN ? 1 : 0);
      end
      apply(2'b01, 1'b1);
      apply(2'b10, 1'b0);
      apply(2'b00, 1'b0);
      if (!DWELL_EN) exp_cnt = exp_cnt + 2'd1;
      e = expv(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL stall_recover got=%b exp=%b", obs(), e); end
   endtask

   task automatic test_async_reset();
      logic [8:0] e;
      apply(2'b01, 1'b0);
      apply(2'b11, 1'b0);
      apply(2'b01, 1'b0);
      e = expv(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, exp_cnt);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL fault_green got=%b exp=%b", obs(), e); end
      #3;
      rst = 1'b1;
      #1;
      e = 9'b100_000_0_00;
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL async_reset got=%b exp=%b", obs(), e); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_cnt = 2'd0;
      apply(2'b00, 1'b0);
      apply(2'b10, 1'b0);
      e = expv(2'b10, 1'b0, 1'b1, 1'b0, 1'b1, exp_cnt);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL post_reset_track got=%b exp=%b", obs(), e); end
   endtask

   // Test sequence and final report.
   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_cycles();
      test_seq_error();
      test_code_error();
      test_clr_ignored();
      test_stall();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8, giving the width of cycle_count.
REQ-002 SHALL have parameter MAX_DWELL, default 16, giving the maximum consecutive cycles one legal code may persist.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port state_in  input  2  light code from the controller: RED=00, GREEN=01, YELLOW=10, 11 illegal.
REQ-006 SHALL have port clr  input  1  synchronous fault clear.
REQ-007 SHALL have ports lamp_red, lamp_green, lamp_yellow  output  1 each  registered one-hot lamp drives.
REQ-008 SHALL have port err_code  output  1  one-cycle pulse: illegal code sampled.
REQ-009 SHALL have port err_seq  output  1  one-cycle pulse: illegal transition sampled.
REQ-010 SHALL have port err_stall  output  1  one-cycle pulse: dwell limit exceeded.
REQ-011 SHALL have port fault  output  1  level, high while the monitor FSM is in FAULT.
REQ-012 SHALL have port cycle_count  output  CNT_W  completed RED-GREEN-YELLOW cycles.

Function
REQ-013 SHALL register state_in into s_cur each clk edge; all outputs are registered, with 1-cycle latency from state_in.
REQ-014 Lamp decode SHALL be: 00 -> red; 01 -> green; 10 -> yellow; 11 -> red only (fail-safe).
REQ-015 Legal transitions (s_cur -> state_in) SHALL be: hold same code, RED->GREEN, GREEN->YELLOW, YELLOW->RED; all others are illegal.
REQ-016 Monitor FSM SHALL have states SYNC, TRACK, FAULT.
REQ-017 SYNC: no sequence, stall or count checks; moves to TRACK on the edge where state_in==RED is sampled.
REQ-018 TRACK: moves to FAULT on any err_code, err_seq or err_stall event.
REQ-019 FAULT: held until clr sampled high, then moves to SYNC; rst also exits FAULT.
REQ-020 err_code SHALL pulse in every FSM state when state_in==11 is sampled; the same sample SHALL NOT also raise err_seq.
REQ-021 A transition out of code 11 SHALL NOT be sequence-checked.
REQ-022 err_seq SHALL pulse only in TRACK, for an illegal transition between two legal codes.
REQ-023 The dwell counter SHALL reset to 1 on each code change and increment while the code holds, saturating at MAX_DWELL+1.
REQ-024 err_stall SHALL pulse once, in TRACK, on the edge where dwell reaches MAX_DWELL+1, and SHALL NOT repeat while the code holds.
REQ-025 cycle_count SHALL increment on each legal YELLOW->RED transition sampled in TRACK, and SHALL wrap from 2^CNT_W-1 to 0.
REQ-026 cycle_count SHALL hold its value in SYNC and FAULT; clr SHALL NOT reset it.
REQ-027 When clr and an error are simultaneous in FAULT, clr SHALL win: next state SYNC, and the error pulse is still reported.
REQ-028 clr SHALL be ignored in SYNC and TRACK.

Reset
REQ-029 While rst is high, the block SHALL asynchronously set: FSM=SYNC, s_cur=RED, dwell=1, lamp_red=1, lamp_green=0, lamp_yellow=0, all err_*=0, fault=0, cycle_count=0.
REQ-030 A mid-operation reset SHALL abort all checks; the first RED sampled after release re-enters TRACK.

Configuration
REQ-031 With macro TL_MON_DWELL_CHECK_EN defined, the dwell counter and err_stall logic SHALL be compiled in as specified.
REQ-032 Without TL_MON_DWELL_CHECK_EN, the dwell counter SHALL be absent, err_stall SHALL be tied to 0, and stall SHALL never cause FAULT.

Verification
REQ-033 Reset, then drive 00,01,10,00 repeated 3 times -> lamps track with 1-cycle lag, cycle_count=3, no errors, fault=0.
REQ-034 In TRACK, drive 00 then 10 -> err_seq pulses 1 cycle, fault=1; next cycle drive clr=1 -> fault=0 and FSM in SYNC.
REQ-035 Drive 11 in SYNC -> err_code pulses, lamp_red=1 only, fault stays 0; drive 11 in TRACK -> err_code and fault=1, err_seq=0.
REQ-036 With TL_MON_DWELL_CHECK_EN, MAX_DWELL=16, hold GREEN 17 cycles -> exactly one err_stall pulse on the 17th sample; without the macro -> no pulse, fault=0.
REQ-037 With CNT_W=2, complete 5 cycles -> cycle_count sequence 1,2,3,0,1.
REQ-038 Assert rst mid-GREEN while in FAULT -> outputs take reset values immediately, asynchronously, without a clk edge.
